// File: rtl/xor_puf_eval_ctrl.sv
`timescale 1ns/1ps
// xor_puf_eval_ctrl
// Sequences reset and excitation of an XOR-PUF cell array and repeats the
// evaluation N_EVAL times. It majority-votes each response bit across those
// evaluations and flags every bit that did not agree on all of them.
// The array's responses are asynchronous to clk and pass through a
// free-running two-flop synchronizer before they are counted.
module xor_puf_eval_ctrl #(
    parameter int N_BITS     = 128,
    parameter int N_EVAL     = 5,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_BITS-1:0]             puf_out,
    output logic                          puf_rn,
    output logic                          puf_i1,
    output logic                          puf_i2,
    output logic                          busy,
    output logic                          done,
    output logic [N_BITS-1:0]             key,
    output logic [N_BITS-1:0]             unstable,
    output logic [$clog2(N_BITS+1)-1:0]   unstable_cnt
);

    localparam int CNT_W  = $clog2(N_BITS + 1);
    localparam int ONES_W = $clog2(N_EVAL + 1);
    localparam int EVAL_W = $clog2(N_EVAL + 1);
    localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? ((RST_CYC > 2) ? RST_CYC : 2)
                                                   : ((SETTLE_CYC > 2) ? SETTLE_CYC : 2);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0]   ARM_LAST  = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0]   FIRE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]   CAPT_LAST = PH_W'(1);
    localparam logic [EVAL_W-1:0] EVAL_LAST = EVAL_W'(N_EVAL - 1);
    localparam logic [ONES_W-1:0] ONES_ALL  = ONES_W'(N_EVAL);
    localparam logic [ONES_W-1:0] ONES_HALF = ONES_W'(N_EVAL / 2);

    // An even evaluation count would allow tied votes, so it is refused at elaboration.
    generate
        if (N_EVAL < 1 || N_EVAL > 15 || (N_EVAL % 2) == 0) begin : g_bad_n_eval
            $error("xor_puf_eval_ctrl: N_EVAL must be odd and within 1..15");
        end
        if (RST_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_windows
            $error("xor_puf_eval_ctrl: RST_CYC and SETTLE_CYC must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FIRE,
        CAPT,
        ACC,
        FIN
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [PH_W-1:0]     phase;
    logic [EVAL_W-1:0]   eval_cnt;
    logic [ONES_W-1:0]   ones [N_BITS];
    logic [N_BITS-1:0]   sync_q1;
    logic [N_BITS-1:0]   sync_q2;
    logic                drive_q;

    logic                drive_d;
    logic                busy_d;
    logic                done_d;
    logic [N_BITS-1:0]   key_d;
    logic [N_BITS-1:0]   unstable_d;
    logic [CNT_W-1:0]    unstable_cnt_d;

    // Free-running two-flop synchronizer on every response bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= puf_out;
            sync_q2 <= sync_q1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; each timed state leaves once its phase counter reaches its last cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = ARM;
            ARM:  if (phase == ARM_LAST) next_state = FIRE;
            FIRE: if (phase == FIRE_LAST) next_state = CAPT;
            CAPT: if (phase == CAPT_LAST) next_state = ACC;
            ACC:  next_state = (eval_cnt == EVAL_LAST) ? FIN : ARM;
            FIN:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state, so the registered array drive lines up with the state.
    always_comb begin
        drive_d = (next_state == FIRE) || (next_state == CAPT) || (next_state == ACC);
        busy_d  = (next_state != IDLE);
        done_d  = (state == FIN);
    end

    // Registered control outputs; I1, I2 and RN all come from one flop so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            drive_q <= drive_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign puf_rn = drive_q;
    assign puf_i1 = drive_q;
    assign puf_i2 = drive_q;

    // Cycle counter within ARM/FIRE/CAPT, restarted on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (state != next_state || state == IDLE) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Per-bit ones counters and evaluation counter; cleared on an accepted start, advanced in ACC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt <= '0;
            for (int i = 0; i < N_BITS; i++) ones[i] <= '0;
        end else if (state == IDLE && start) begin
            eval_cnt <= '0;
            for (int i = 0; i < N_BITS; i++) ones[i] <= '0;
        end else if (state == ACC) begin
            eval_cnt <= eval_cnt + 1'b1;
            for (int i = 0; i < N_BITS; i++) ones[i] <= ones[i] + ONES_W'(sync_q2[i]);
        end
    end

    // Majority vote, instability flags and their popcount from the finished counters.
    always_comb begin
        key_d          = '0;
        unstable_d     = '0;
        unstable_cnt_d = '0;
        for (int i = 0; i < N_BITS; i++) begin
            key_d[i]       = (ones[i] > ONES_HALF);
            unstable_d[i]  = (ones[i] != '0) && (ones[i] != ONES_ALL);
            unstable_cnt_d = unstable_cnt_d + CNT_W'(unstable_d[i]);
        end
    end

    // Result registers only change in FIN and otherwise hold the previous run's outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key          <= '0;
            unstable     <= '0;
            unstable_cnt <= '0;
        end else if (state == FIN) begin
            key          <= key_d;
            unstable     <= unstable_d;
            unstable_cnt <= unstable_cnt_d;
        end
    end

endmodule

// File: tb/tb_xor_puf_eval_ctrl.sv
`timescale 1ns/1ps
// tb_xor_puf_eval_ctrl
// Directed bench: a default-parameter instance driven by a small array model
// that returns a per-evaluation pattern while I1 is high, plus a minimal
// instance (N_EVAL=1, RST_CYC=1, SETTLE_CYC=1) with a constant random response.
module tb_xor_puf_eval_ctrl;

    localparam int NB = 128;
    localparam logic [NB-1:0] PAT_A5 = {16{8'hA5}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start_a;
    logic          start_b;
    logic [NB-1:0] puf_out_a;
    logic [NB-1:0] puf_out_b;

    logic          puf_rn_a, puf_i1_a, puf_i2_a, busy_a, done_a;
    logic [NB-1:0] key_a, unstable_a;
    logic [7:0]    unstable_cnt_a;

    logic          puf_rn_b, puf_i1_b, puf_i2_b, busy_b, done_b;
    logic [NB-1:0] key_b, unstable_b;
    logic [7:0]    unstable_cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NB-1:0] seq_pat [5];
    logic          fire_clr = 1'b0;
    int            fire_cnt = 0;

    xor_puf_eval_ctrl #(
        .N_BITS(NB), .N_EVAL(5), .RST_CYC(4), .SETTLE_CYC(8)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .puf_out(puf_out_a),
        .puf_rn(puf_rn_a), .puf_i1(puf_i1_a), .puf_i2(puf_i2_a),
        .busy(busy_a), .done(done_a), .key(key_a), .unstable(unstable_a),
        .unstable_cnt(unstable_cnt_a)
    );

    xor_puf_eval_ctrl #(
        .N_BITS(NB), .N_EVAL(1), .RST_CYC(1), .SETTLE_CYC(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .puf_out(puf_out_b),
        .puf_rn(puf_rn_b), .puf_i1(puf_i1_b), .puf_i2(puf_i2_b),
        .busy(busy_b), .done(done_b), .key(key_b), .unstable(unstable_b),
        .unstable_cnt(unstable_cnt_b)
    );

    // Array model: count excitation pulses so each evaluation can see its own pattern.
    always @(posedge puf_i1_a or posedge fire_clr) begin
        if (fire_clr) fire_cnt = 0;
        else          fire_cnt = fire_cnt + 1;
    end

    // Array model output: the current evaluation's pattern while excited, zero otherwise.
    always_comb begin
        puf_out_a = '0;
        if (puf_i1_a && fire_cnt >= 1 && fire_cnt <= 5) puf_out_a = seq_pat[fire_cnt-1];
    end

    task automatic checkOutput(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // Load the five per-evaluation patterns and restart the model's pulse count.
    task automatic applyStimulus(input logic [NB-1:0] p0, input logic [NB-1:0] p1,
                                 input logic [NB-1:0] p2, input logic [NB-1:0] p3,
                                 input logic [NB-1:0] p4);
        seq_pat[0] = p0;
        seq_pat[1] = p1;
        seq_pat[2] = p2;
        seq_pat[3] = p3;
        seq_pat[4] = p4;
        fire_clr = 1'b1;
        #1;
        fire_clr = 1'b0;
    endtask

    // One START on instance A, called at a negedge. Cycle c is the c-th negedge after the
    // START edge. Optional mid-run START, hold check of KEY, async reset and window checks.
    task automatic runA(input int restart_at, input int hold_at, input logic [NB-1:0] hold_key,
                        input int rst_at, input bit chk_win, output int done_cyc);
        int rn_low;
        int i1_high;
        int i_diff;
        done_cyc = -1;
        rn_low   = 0;
        i1_high  = 0;
        i_diff   = 0;
        start_a  = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        checkOutput("busy_rise", NB'(busy_a), NB'(1));
        for (int c = 1; c <= 200; c++) begin
            if (c <= 15) begin
                rn_low  += int'(!puf_rn_a);
                i1_high += int'(puf_i1_a);
            end
            i_diff += int'(puf_i1_a != puf_i2_a);
            if (done_a) begin
                done_cyc = c;
                break;
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort_puf_rn",   NB'(puf_rn_a), NB'(0));
                checkOutput("abort_puf_i1",   NB'(puf_i1_a), NB'(0));
                checkOutput("abort_busy",     NB'(busy_a), NB'(0));
                checkOutput("abort_done",     NB'(done_a), NB'(0));
                checkOutput("abort_key",      key_a, '0);
                checkOutput("abort_unstable", unstable_a, '0);
                checkOutput("abort_cnt",      NB'(unstable_cnt_a), NB'(0));
                #2;
                rst_n = 1'b1;
                done_cyc = -2;
                break;
            end
            start_a = (c == restart_at);
            if (c == hold_at) checkOutput("key_hold", key_a, hold_key);
            @(negedge clk);
        end
        start_a = 1'b0;
        checkOutput("i1_eq_i2", NB'(i_diff), NB'(0));
        if (chk_win) begin
            checkOutput("rst_window",    NB'(rn_low),  NB'(4));
            checkOutput("excite_window", NB'(i1_high), NB'(11));
        end
    endtask

    initial begin
        int            dc;
        logic [NB-1:0] rnd;
        logic [NB-1:0] b0;
        logic [NB-1:0] b7;
        logic [NB-1:0] b9;

        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        puf_out_b = '0;
        applyStimulus('0, '0, '0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_puf_rn",   NB'(puf_rn_a), NB'(0));
        checkOutput("rst_puf_i1",   NB'(puf_i1_a), NB'(0));
        checkOutput("rst_puf_i2",   NB'(puf_i2_a), NB'(0));
        checkOutput("rst_busy",     NB'(busy_a), NB'(0));
        checkOutput("rst_done",     NB'(done_a), NB'(0));
        checkOutput("rst_key",      key_a, '0);
        checkOutput("rst_unstable", unstable_a, '0);
        checkOutput("rst_cnt",      NB'(unstable_cnt_a), NB'(0));

        // Release without START: nothing moves
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("idle_puf_rn", NB'(puf_rn_a), NB'(0));
        checkOutput("idle_busy",   NB'(busy_a), NB'(0));
        checkOutput("idle_done",   NB'(done_a), NB'(0));
        checkOutput("idle_key",    key_a, '0);

        // Stable array
        applyStimulus(PAT_A5, PAT_A5, PAT_A5, PAT_A5, PAT_A5);
        runA(-1, -1, '0, -1, 1'b1, dc);
        checkOutput("stable_done_cyc", NB'(dc), NB'(77));
        checkOutput("stable_key",      key_a, PAT_A5);
        checkOutput("stable_unstable", unstable_a, '0);
        checkOutput("stable_cnt",      NB'(unstable_cnt_a), NB'(0));
        checkOutput("stable_busy_low", NB'(busy_a), NB'(0));
        @(negedge clk);
        checkOutput("done_one_cycle",  NB'(done_a), NB'(0));

        // Noisy bits: bit0 1,0,1,0,1 / bit7 0,1,0,0,1 / bit9 always 1
        b0 = '0; b0[0] = 1'b1;
        b7 = '0; b7[7] = 1'b1;
        b9 = '0; b9[9] = 1'b1;
        applyStimulus(b0 | b9, b7 | b9, b0 | b9, b9, b0 | b7 | b9);
        runA(-1, -1, '0, -1, 1'b0, dc);
        checkOutput("noisy_done_cyc", NB'(dc), NB'(77));
        checkOutput("noisy_key",      key_a, NB'(128'h201));
        checkOutput("noisy_unstable", unstable_a, NB'(128'h81));
        checkOutput("noisy_cnt",      NB'(unstable_cnt_a), NB'(2));

        // Async reset in the third ACC (cycle 45) clears the noisy results
        @(negedge clk);
        applyStimulus(b0 | b9, b7 | b9, b0 | b9, b9, b0 | b7 | b9);
        runA(-1, -1, '0, 45, 1'b0, dc);
        checkOutput("abort_before_done", NB'(dc), NB'(-2));

        // Clean run afterwards, with an ignored START at cycle 30
        @(negedge clk);
        applyStimulus(PAT_A5, PAT_A5, PAT_A5, PAT_A5, PAT_A5);
        runA(30, -1, '0, -1, 1'b1, dc);
        checkOutput("restart_done_cyc", NB'(dc), NB'(77));
        checkOutput("restart_key",      key_a, PAT_A5);
        checkOutput("restart_unstable", unstable_a, '0);
        checkOutput("restart_cnt",      NB'(unstable_cnt_a), NB'(0));

        // Second START with a silent array; old key must survive until the new DONE
        @(negedge clk);
        @(negedge clk);
        checkOutput("no_queued_start", NB'(busy_a), NB'(0));
        applyStimulus('0, '0, '0, '0, '0);
        runA(-1, 76, PAT_A5, -1, 1'b0, dc);
        checkOutput("zero_done_cyc", NB'(dc), NB'(77));
        checkOutput("zero_key",      key_a, '0);
        checkOutput("zero_unstable", unstable_a, '0);
        checkOutput("zero_cnt",      NB'(unstable_cnt_a), NB'(0));

        // Minimal instance: single evaluation of a random response
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        puf_out_b = rnd;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        dc = -1;
        for (int c = 1; c <= 50; c++) begin
            if (done_b) begin
                dc = c;
                break;
            end
            @(negedge clk);
        end
        checkOutput("b_done_cyc",  NB'(dc), NB'(7));
        checkOutput("b_key",       key_b, rnd);
        checkOutput("b_unstable",  unstable_b, '0);
        checkOutput("b_cnt",       NB'(unstable_cnt_b), NB'(0));
        checkOutput("b_busy_low",  NB'(busy_b), NB'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
